// File: rtl/seg7_decoder.sv
// Seven-segment display decoder: samples five active-low digit patterns,
// waits for them to be stable, then emits the decoded PC, register and
// status values through a valid/ready handshake or flags an invalid digit.
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seg_en,
  input  logic [6:0] display1,
  input  logic [6:0] display2,
  input  logic [6:0] display3,
  input  logic [6:0] display4,
  input  logic [6:0] display5,
  output logic [7:0] pc_out,
  output logic [7:0] reg_out,
  output logic [3:0] final_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [2:0] err_digit
);

  localparam logic [3:0] SAT = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, ERROR} state_t;

  state_t      state, state_n;
  logic [34:0] sample, sample_n;
  logic [34:0] last_pattern, last_pattern_n;
  logic        lp_valid, lp_valid_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  pc_n, reg_n;
  logic [3:0]  final_n;
  logic        ov_n, err_n;
  logic [2:0]  err_digit_n;

  logic [34:0] din;
  logic [4:0]  dig_ok;
  logic [3:0]  dig_val [5];
  logic [2:0]  first_bad;

  assign din = {display5, display4, display3, display2, display1};

  // Map one active-low pattern to {valid, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: return {1'b1, 4'h0};
      7'b1111001: return {1'b1, 4'h1};
      7'b0100100: return {1'b1, 4'h2};
      7'b0110000: return {1'b1, 4'h3};
      7'b0011001: return {1'b1, 4'h4};
      7'b0010010: return {1'b1, 4'h5};
      7'b0000010: return {1'b1, 4'h6};
      7'b1111000: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0010000: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b0000011: return {1'b1, 4'hB};
      7'b1000110: return {1'b1, 4'hC};
      7'b0100001: return {1'b1, 4'hD};
      7'b0000110: return {1'b1, 4'hE};
      7'b0001110: return {1'b1, 4'hF};
      default:    return '0;
    endcase
  endfunction

  // Decode the held sample and locate the lowest-numbered invalid digit.
  always_comb begin
    first_bad = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      {dig_ok[i], dig_val[i]} = seg_decode(sample[7*i +: 7]);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      if (!dig_ok[4-i]) first_bad = 3'(5 - i);
    end
  end

  // Next-state logic for the FSM, counter, sample and result registers.
  always_comb begin
    state_n        = state;
    sample_n       = sample;
    last_pattern_n = last_pattern;
    lp_valid_n     = lp_valid;
    cnt_n          = cnt;
    pc_n           = pc_out;
    reg_n          = reg_out;
    final_n        = final_out;
    ov_n           = out_valid;
    err_n          = err;
    err_digit_n    = err_digit;

    if (out_valid && out_ready) ov_n = 1'b0;

    if (seg_en) begin
      sample_n = din;
      // The counter restarts on the enabling edge even if the frozen sample
      // still matches, so a re-enable always costs a full settle period.
      if (state == IDLE)      cnt_n = '0;
      else if (din == sample) cnt_n = (cnt == SAT) ? cnt : cnt + 4'd1;
      else                    cnt_n = '0;

      case (state)
        IDLE: state_n = SETTLE;
        SETTLE: begin
          if (cnt == SAT) begin
            if (&dig_ok) begin
              if (!out_valid || out_ready) begin
                pc_n           = {dig_val[1], dig_val[0]};
                reg_n          = {dig_val[3], dig_val[2]};
                final_n        = dig_val[4];
                ov_n           = 1'b1;
                last_pattern_n = sample;
                lp_valid_n     = 1'b1;
                err_n          = 1'b0;
                err_digit_n    = '0;
                state_n        = HOLD;
              end
            end else begin
              err_n       = 1'b1;
              err_digit_n = first_bad;
              state_n     = ERROR;
            end
          end
        end
        HOLD: begin
          if (!lp_valid || din != last_pattern) begin
            cnt_n   = '0;
            state_n = SETTLE;
          end
        end
        ERROR: begin
          if (din != sample) begin
            err_n       = 1'b0;
            err_digit_n = '0;
            state_n     = SETTLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else begin
      cnt_n   = '0;
      state_n = IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sample       <= '1;
      last_pattern <= '0;
      lp_valid     <= 1'b0;
      cnt          <= '0;
      pc_out       <= '0;
      reg_out      <= '0;
      final_out    <= '0;
      out_valid    <= 1'b0;
      err          <= 1'b0;
      err_digit    <= '0;
    end else begin
      state        <= state_n;
      sample       <= sample_n;
      last_pattern <= last_pattern_n;
      lp_valid     <= lp_valid_n;
      cnt          <= cnt_n;
      pc_out       <= pc_n;
      reg_out      <= reg_n;
      final_out    <= final_n;
      out_valid    <= ov_n;
      err          <= err_n;
      err_digit    <= err_digit_n;
    end
  end

endmodule
